// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared processor constants: opcodes, register-file states, default widths
package processor_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  localparam logic [3:0] LW  = 4'h0;
  localparam logic [3:0] SW  = 4'h1;
  localparam logic [3:0] MOV = 4'h2;
  localparam logic [3:0] ADD = 4'h3;
  localparam logic [3:0] SUB = 4'h4;
  localparam logic [3:0] MUL = 4'h5;
  localparam logic [3:0] DIV = 4'h6;
  localparam logic [3:0] AND = 4'h7;
  localparam logic [3:0] OR  = 4'h8;
  localparam logic [3:0] XOR = 4'h9;
  localparam logic [3:0] NOT = 4'hA;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - per-register busy bits with set/clear/flush and two lookup ports
module register_scoreboard
  import processor_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  flush_i,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] lookup1_addr_i,
  input  logic [ADDR_WIDTH-1:0] lookup2_addr_i,
  output logic                  lookup1_busy_o,
  output logic                  lookup2_busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-cycle reserve wins over writeback.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) busy_q <= '0;
    else            busy_q <= busy_d;
  end

  assign lookup1_busy_o = busy_q[lookup1_addr_i];
  assign lookup2_busy_o = busy_q[lookup2_addr_i];

endmodule

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - register file with busy scoreboard and zero sweep
// Optional same-cycle write-to-read bypass under REGISTER_FILE_BYPASS_EN.
module register_file_scoreboard
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_request,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reserve_enable,
  input  logic [ADDR_WIDTH-1:0] reserve_address,
  input  logic [ADDR_WIDTH-1:0] read_address1,
  input  logic [ADDR_WIDTH-1:0] read_address2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  read_busy1,
  output logic                  read_busy2,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH-1);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   counter_q, counter_d;
  logic [DATA_WIDTH-1:0] entry_q [DEPTH];

  logic                  in_ready;
  logic                  write_accept;
  logic                  reserve_accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_busy [2];
  logic                  sb_busy [2];

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign in_ready       = (state_q == READY);
  assign write_accept   = in_ready && write_enable && !clear_request && !is_zero_reg(write_address);
  assign reserve_accept = in_ready && reserve_enable && !clear_request && !is_zero_reg(reserve_address);

  // The sweep shares the single write port; outside READY it owns it every cycle.
  assign mem_we   = !in_ready || write_accept;
  assign mem_addr = in_ready ? write_address : counter_q[ADDR_WIDTH-1:0];
  assign mem_data = in_ready ? write_data : '0;

  always_ff @(posedge clock) begin
    if (mem_we) entry_q[mem_addr] <= mem_data;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      CLEAR: begin
        counter_d = counter_q + 1'b1;
        if (counter_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        if (clear_request) begin
          state_d   = CLEAR;
          counter_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        counter_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  register_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clock_i        (clock),
    .reset_n_i      (reset_n),
    .flush_i        (in_ready && clear_request),
    .set_en_i       (reserve_accept),
    .set_addr_i     (reserve_address),
    .clr_en_i       (mem_we),
    .clr_addr_i     (mem_addr),
    .lookup1_addr_i (rd_addr[0]),
    .lookup2_addr_i (rd_addr[1]),
    .lookup1_busy_o (sb_busy[0]),
    .lookup2_busy_o (sb_busy[1])
  );

  assign rd_addr[0] = read_address1;
  assign rd_addr[1] = read_address2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (in_ready && !is_zero_reg(rd_addr[p])) begin
        rd_data[p] = entry_q[rd_addr[p]];
        rd_busy[p] = sb_busy[p];
`ifdef REGISTER_FILE_BYPASS_EN
        if (write_accept && (rd_addr[p] == write_address)) begin
          rd_data[p] = write_data;
          rd_busy[p] = reserve_accept && (reserve_address == rd_addr[p]);
        end
`endif
      end
    end
  end

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];
  assign read_busy1 = rd_busy[0];
  assign read_busy2 = rd_busy[1];
  assign ready      = in_ready;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - directed scoreboard bench for register_file_scoreboard
module tb_register_file_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_request = 1'b0;
  logic        write_enable = 1'b0;
  logic [4:0]  write_address = '0;
  logic [31:0] write_data = '0;
  logic        reserve_enable = 1'b0;
  logic [4:0]  reserve_address = '0;
  logic [4:0]  read_address1 = '0;
  logic [4:0]  read_address2 = '0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        read_busy1;
  logic        read_busy2;
  logic        ready;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  register_file_scoreboard dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .clear_request   (clear_request),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_data      (write_data),
    .reserve_enable  (reserve_enable),
    .reserve_address (reserve_address),
    .read_address1   (read_address1),
    .read_address2   (read_address2),
    .read_data1      (read_data1),
    .read_data2      (read_data2),
    .read_busy1      (read_busy1),
    .read_busy2      (read_busy2),
    .ready           (ready)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) step();
    expect_val(32'd0); check("reset_ready", {31'd0, ready});
    reset_n = 1'b1;
    wait_ready(n);
    expect_val(32'd32); check("ready_latency", n);

    for (int i = 0; i < 32; i++) begin
      read_address1 = 5'(i);
      read_address2 = 5'(31 - i);
      #1;
      expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
      check("sweep_data1", read_data1);
      check("sweep_busy1", {31'd0, read_busy1});
      check("sweep_data2", read_data2);
      check("sweep_busy2", {31'd0, read_busy2});
    end
    step();

    write_enable = 1'b1; write_address = 5'd5; write_data = 32'hDEADBEEF;
    step();
    write_enable = 1'b0; read_address1 = 5'd5; #1;
    expect_val(32'hDEADBEEF); check("r5_data", read_data1);

    write_enable = 1'b1; write_address = 5'd0; write_data = 32'h00001234;
    step();
    write_enable = 1'b0; read_address2 = 5'd0; #1;
    expect_val(32'd0); check("r0_data", read_data2);

    reserve_enable = 1'b1; reserve_address = 5'd7;
    step();
    reserve_enable = 1'b0; read_address2 = 5'd7; #1;
    expect_val(32'd1); check("r7_busy", {31'd0, read_busy2});
    expect_val(32'd0); check("r5_not_busy", {31'd0, read_busy1});

    reserve_enable = 1'b1; reserve_address = 5'd0;
    step();
    reserve_enable = 1'b0; read_address1 = 5'd0; #1;
    expect_val(32'd0); check("r0_busy", {31'd0, read_busy1});

    write_enable = 1'b1; write_address = 5'd7; write_data = 32'h12;
    step();
    write_enable = 1'b0; #1;
    expect_val(32'h12); check("r7_wr_data", read_data2);
    expect_val(32'd0);  check("r7_wr_busy", {31'd0, read_busy2});

    write_enable = 1'b1; write_address = 5'd7; write_data = 32'h99;
    reserve_enable = 1'b1; reserve_address = 5'd7;
    step();
    write_enable = 1'b0; reserve_enable = 1'b0; #1;
    expect_val(32'h99); check("r7_wrrsv_data", read_data2);
    expect_val(32'd1);  check("r7_wrrsv_busy", {31'd0, read_busy2});

    reserve_enable = 1'b1; reserve_address = 5'd3;
    step();
    reserve_enable = 1'b0;
    read_address1 = 5'd3;
    write_enable = 1'b1; write_address = 5'd3; write_data = 32'hA5A5A5A5;
    #1;
`ifdef REGISTER_FILE_BYPASS_EN
    expect_val(32'hA5A5A5A5); expect_val(32'd0);
`else
    expect_val(32'd0); expect_val(32'd1);
`endif
    check("r3_same_cycle_data", read_data1);
    check("r3_same_cycle_busy", {31'd0, read_busy1});
    step();
    write_enable = 1'b0; #1;
    expect_val(32'hA5A5A5A5); check("r3_next_data", read_data1);
    expect_val(32'd0);        check("r3_next_busy", {31'd0, read_busy1});

    read_address2 = 5'd4;
    write_enable = 1'b1; write_address = 5'd4; write_data = 32'h0BADF00D;
    reserve_enable = 1'b1; reserve_address = 5'd4;
    #1;
`ifdef REGISTER_FILE_BYPASS_EN
    expect_val(32'h0BADF00D); expect_val(32'd1);
`else
    expect_val(32'd0); expect_val(32'd0);
`endif
    check("r4_same_cycle_data", read_data2);
    check("r4_same_cycle_busy", {31'd0, read_busy2});
    step();
    write_enable = 1'b0; reserve_enable = 1'b0; #1;
    expect_val(32'h0BADF00D); check("r4_next_data", read_data2);
    expect_val(32'd1);        check("r4_next_busy", {31'd0, read_busy2});

    write_enable = 1'b1; write_address = 5'd9; write_data = 32'h55;
    reserve_enable = 1'b1; reserve_address = 5'd9;
    step();
    write_enable = 1'b0; reserve_enable = 1'b0;
    read_address1 = 5'd9; #1;
    expect_val(32'h55); check("r9_pre_data", read_data1);
    expect_val(32'd1);  check("r9_pre_busy", {31'd0, read_busy1});

    clear_request = 1'b1;
    step();
    clear_request = 1'b0;
    read_address1 = 5'd5; read_address2 = 5'd7;
    write_enable = 1'b1; write_address = 5'd9; write_data = 32'hFF;
    #1;
    expect_val(32'd0); check("clear_ready", {31'd0, ready});
    expect_val(32'd0); check("clear_r5_data", read_data1);
    expect_val(32'd0); check("clear_r7_busy", {31'd0, read_busy2});
    wait_ready(n);
    write_enable = 1'b0;
    expect_val(32'd32); check("clear_latency", n);
    read_address1 = 5'd9; read_address2 = 5'd5; #1;
    expect_val(32'd0); check("r9_post_data", read_data1);
    expect_val(32'd0); check("r9_post_busy", {31'd0, read_busy1});
    expect_val(32'd0); check("r5_post_data", read_data2);
    step();

    write_enable = 1'b1; write_address = 5'd5; write_data = 32'hCAFE0001;
    step();
    write_enable = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (10) step();
    reset_n = 1'b0; #1;
    expect_val(32'd0); check("midsweep_ready", {31'd0, ready});
    step();
    reset_n = 1'b1;
    wait_ready(n);
    expect_val(32'd32); check("midsweep_latency", n);
    read_address1 = 5'd5; read_address2 = 5'd4; #1;
    expect_val(32'd0); check("post_reset_r5", read_data1);
    expect_val(32'd0); check("post_reset_r4_busy", {31'd0, read_busy2});
    step();

    write_enable = 1'b1; write_address = 5'd12; write_data = 32'h600DF00D;
    step();
    write_enable = 1'b0; read_address1 = 5'd12; #1;
    expect_val(32'h600DF00D); check("r12_after_reset", read_data1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
